// File: rtl/pwm_shadow_gen.sv
// pwm_shadow_gen: prescaled PWM generator with a period-boundary shadow duty
// register and a one-clock period tick for pacing upstream sequencers.
// Optional build macro PWM_CENTER_ALIGN_EN selects a centre-aligned (triangle)
// counter in place of the default edge-aligned sawtooth.
module pwm_shadow_gen #(
  parameter int unsigned R      = 8,
  parameter int unsigned DVSR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [R:0]        duty,
  output logic              pwm_out,
  output logic              period_tick
);

  localparam logic [R-1:0] D_MAX = '1;
  localparam logic [R:0]   FULL  = {1'b1, {R{1'b0}}};

  logic [DVSR_W-1:0] q_q, q_d;
  logic [R-1:0]      d_q, d_d;
  logic [R:0]        shadow_q, shadow_d;
  logic              pwm_q, pwm_d;
  logic              tick_q, tick_d;
  logic [R:0]        duty_sat;
  logic              step;
  logic              wrap;
`ifdef PWM_CENTER_ALIGN_EN
  logic              dir_q, dir_d;
`endif

  // Saturated duty, prescaler step (>= so a lowered divisor never locks up)
  always_comb begin
    duty_sat = (duty > FULL) ? FULL : duty;
    step     = (q_q >= dvsr);
  end

  // Next-state logic for prescaler, period counter, shadow and outputs
  always_comb begin
    q_d      = q_q;
    d_d      = d_q;
    shadow_d = shadow_q;
    pwm_d    = 1'b0;
    tick_d   = 1'b0;
    wrap     = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d    = dir_q;
`endif
    if (!en) begin
      q_d      = '0;
      d_d      = '0;
      shadow_d = duty_sat;
`ifdef PWM_CENTER_ALIGN_EN
      dir_d    = 1'b0;
`endif
    end else begin
      q_d = step ? '0 : q_q + DVSR_W'(1);
`ifdef PWM_CENTER_ALIGN_EN
      // Both turnaround values repeat once: the step that flips dir holds d.
      wrap = step && dir_q && (d_q == '0);
      if (step) begin
        if (!dir_q) begin
          if (d_q == D_MAX) dir_d = 1'b1;
          else              d_d   = d_q + R'(1);
        end else begin
          if (d_q == '0)    dir_d = 1'b0;
          else              d_d   = d_q - R'(1);
        end
      end
`else
      wrap = step && (d_q == D_MAX);
      if (step) d_d = d_q + R'(1);
`endif
      if (wrap) shadow_d = duty_sat;
      pwm_d  = ({1'b0, d_q} < shadow_q);
      tick_d = wrap;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q      <= '0;
      d_q      <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      q_q      <= q_d;
      d_q      <= d_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// tb_pwm_shadow_gen: directed bench for pwm_shadow_gen with R=4.
// Cycle index k counts clock edges after enable rises (or reset releases);
// outputs are sampled 1 time unit after each rising edge.
module tb_pwm_shadow_gen;

  localparam int unsigned R      = 4;
  localparam int unsigned DVSR_W = 32;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int PER = 32;
`else
  localparam int PER = 16;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [DVSR_W-1:0] dvsr = '0;
  logic [R:0]        duty = 5'd8;
  logic              pwm_out;
  logic              period_tick;

  int tests = 0;
  int fails = 0;

  pwm_shadow_gen #(.R(R), .DVSR_W(DVSR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .dvsr(dvsr), .duty(duty),
    .pwm_out(pwm_out), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Counter value seen before edge k, for divisor dv, starting at 0 on edge 1
  function automatic int cnt_at(input int k, input int dv);
    int s;
    s = ((k - 1) / (dv + 1)) % PER;
`ifdef PWM_CENTER_ALIGN_EN
    if (s >= 16) s = 31 - s;
`endif
    return s;
  endfunction

  function automatic logic exp_pwm(input int k, input int dv, input int d);
    int ds;
    ds = (d > 16) ? 16 : d;
    return (cnt_at(k, dv) < ds);
  endfunction

  function automatic logic exp_tick(input int k, input int dv);
    return ((k % ((dv + 1) * PER)) == 0);
  endfunction

  // Pulse en low for one edge so the shadow picks up duty, then enable
  task automatic restart(input string tag, input int dv, input int d);
    en   = 1'b0;
    dvsr = DVSR_W'(dv);
    duty = (R+1)'(d);
    step();
    chk({tag, "_off_pwm"}, 0, pwm_out, 1'b0);
    chk({tag, "_off_tick"}, 0, period_tick, 1'b0);
    en = 1'b1;
  endtask

  task automatic run(input string tag, input int dv, input int d, input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      chk({tag, "_pwm"}, k, pwm_out, exp_pwm(k, dv, d));
      chk({tag, "_tick"}, k, period_tick, exp_tick(k, dv));
    end
  endtask

  initial begin
    int t5, low_end, tp;
`ifdef PWM_CENTER_ALIGN_EN
    t5 = 101; low_end = 98;
`else
    t5 = 53;  low_end = 53;
`endif

    // Reset state
    step();
    step();
    chk("rst_pwm", 0, pwm_out, 1'b0);
    chk("rst_tick", 0, period_tick, 1'b0);
    rst = 1'b0;

    // 1: dvsr=0, duty=8
    restart("t1", 0, 8);
    run("t1", 0, 8, 2 * PER);

    // 2: duty extremes and saturation
    restart("t2z", 0, 0);
    run("t2z", 0, 0, PER + 2);
    restart("t2f", 0, 16);
    run("t2f", 0, 16, PER + 2);
    restart("t2s", 0, 31);
    run("t2s", 0, 31, PER + 2);

    // 3: duty change mid-period only takes effect after the next wrap
    restart("t3", 0, 4);
    for (int k = 1; k <= 2 * PER; k++) begin
      step();
      if (k == 5) duty = 5'd12;
      chk("t3_pwm", k, pwm_out, exp_pwm(k, 0, (k <= PER) ? 4 : 12));
      chk("t3_tick", k, period_tick, exp_tick(k, 0));
    end

    // 4: prescaled, dvsr=2
    restart("t4", 2, 8);
    run("t4", 2, 8, 3 * PER + 4);

    // 5: lower dvsr from 10 to 2 while prescaler sits at 7
    restart("t5", 10, 1);
    for (int k = 1; k <= t5 + 5; k++) begin
      step();
      if (k == 7) dvsr = 32'd2;
      chk("t5_pwm", k, pwm_out, (k <= 8) || (k > low_end && k <= t5 + 3));
      chk("t5_tick", k, period_tick, k == t5);
    end

    // 5b: reset mid-period clears outputs, counters and shadow
    rst = 1'b1;
    step();
    chk("t5r_pwm", 0, pwm_out, 1'b0);
    chk("t5r_tick", 0, period_tick, 1'b0);
    rst = 1'b0;
    tp = 3 * PER;
    for (int k = 1; k <= tp + 2; k++) begin
      step();
      chk("t5r_run_pwm", k, pwm_out, (k > tp) && exp_pwm(k, 2, 1));
      chk("t5r_run_tick", k, period_tick, k == tp);
    end

    // 6: en low for 20 clocks, then a clean first period
    dvsr = '0;
    duty = 5'd6;
    en   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("t6_off_pwm", k, pwm_out, 1'b0);
      chk("t6_off_tick", k, period_tick, 1'b0);
    end
    en = 1'b1;
    run("t6", 0, 6, 2 * PER);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
